icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Fetch-side controller for the direct-mapped instruction cache.
- Takes PC requests from the IF stage and probes the cache. On a hit it returns the cached word. On a miss it reads the 4 instruction bytes from the byte-wide memory port, assembles them little-endian, writes the word into the cache (data_i/work) and returns it to IF.
- Sits between IF, the cache, and the memory arbiter.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus).
- INST_W, 32, instruction width (matches InstBus).
- NBYTES, 4, bytes fetched per miss (INST_W/8).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state and outputs freeze
- if_req  in  1  IF requests an instruction; held with if_pc until inst_valid
- if_pc  in  ADDR_W  requested PC, word-aligned
- flush  in  1  branch redirect; aborts the current request
- inst_valid  out  1  one-cycle pulse, inst is valid
- inst  out  INST_W  fetched instruction
- cache_addr  out  ADDR_W  lookup/write address to cache
- cache_wdata  out  INST_W  word written to cache (cache data_i)
- cache_we  out  1  cache write strobe (cache work)
- cache_rdata  in  INST_W  cache data_o
- cache_hit  in  1  cache isHit
- mem_grant  in  1  arbiter grants the memory port this cycle
- mem_rd  out  1  byte read request
- mem_addr  out  ADDR_W  byte address
- mem_din  in  8  read byte; valid exactly 1 cycle after a granted mem_rd

Behaviour:
- Reset: state=IDLE, inst_valid=0, inst=0, cache_we=0, cache_wdata=0, mem_rd=0, mem_addr=0, issue_cnt=0, recv_cnt=0, word buffer=0.
- Reset mid-refill: refill is abandoned and no cache write occurs.
- rdy=0: no register updates. An outstanding byte returned while rdy=0 is not captured; the bench holds rdy=1 while mem_rd is in flight (system guarantee).
- cache_addr = if_pc in IDLE; in all other states it is the latched PC (pc_q).

States:
- IDLE
  - if_req & !flush & cache_hit: next cycle inst=cache_rdata, inst_valid=1; stay IDLE (latency 1).
  - if_req & !flush & !cache_hit: latch pc_q=if_pc, clear counters, go FETCH.
- FETCH
  - mem_rd = (issue_cnt<NBYTES); mem_addr = pc_q + issue_cnt.
  - issue_cnt increments only when mem_rd & mem_grant.
  - Each cycle after a granted issue, mem_din is stored into byte[recv_cnt] (bits 8k+7:8k) and recv_cnt increments.
  - When recv_cnt reaches NBYTES (the 4th byte was captured this cycle), go DONE.
- DONE (1 cycle)
  - cache_we=1, cache_wdata=word, inst=word, inst_valid=1; return to IDLE.
- Uncontended miss timing:
  - Miss seen cycle 0; issue bytes cycles 1-4; receive bytes cycles 2-5; DONE cycle 6.
  - Miss latency = 6 cycles; each cycle of mem_grant=0 adds one.
- Request turnaround: if_req is ignored in the cycle inst_valid is high. IDLE evaluates if_req/if_pc again on the following cycle.
- flush (any state, rdy=1):
  - Next state IDLE; inst_valid=0, cache_we=0, counters cleared.
  - A byte in flight is discarded; no partial word is ever written to the cache.
  - flush takes priority over a same-cycle hit or DONE.
- PC is never wrapped beyond ADDR_W: byte address = pc_q + {0..3} modulo 2^ADDR_W.
- inst_valid and cache_we are never high for more than one consecutive cycle.

Decomposition:
- Shared config package:
  - InstAddrBus/InstBus widths.
  - State encodings (IDLE=2'd0, FETCH=2'd1, DONE=2'd2).
  - Byte-count constant NBYTES.
- Sub-module: one natural sub-module, byte_assembler (byte-lane shift/store with recv_cnt and clear). Everything else stays in icache_refill.

Test Plan:
- Hit:
  - Preload the cache at 0x0000_1000 with 0x00A00093.
  - if_req with pc 0x1000 -> inst_valid one cycle later, inst=0x00A00093, mem_rd never asserted.
- Cold miss:
  - pc 0x0000_0004, memory bytes 13 05 00 00.
  - mem_addr 4,5,6,7 on cycles 1-4.
  - Cycle 6: inst_valid=1, inst=0x00000513, cache_we=1, cache_addr=4.
  - Re-request of pc 4 then hits with latency 1.
- Grant stalls:
  - Same miss, mem_grant low on cycles 2 and 3.
  - mem_addr held during the stall, no byte duplicated; DONE on cycle 8 with the correct word.
- Flush mid-refill:
  - flush on cycle 3 of a miss -> IDLE next cycle, cache_we never asserted, no inst_valid.
  - A subsequent request for a different PC fetches correctly.
- Reset and rdy:
  - rst asserted during FETCH -> all outputs 0 next cycle.
  - rdy low for 3 cycles during IDLE/DONE -> state, inst and inst_valid frozen, then resume.
- Back-to-back:
  - Hit at 0x1000, then a miss at 0x2000 presented the cycle after inst_valid.
  - No request is dropped; each request produces exactly one inst_valid pulse.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared widths, FSM encodings and counter types for the instruction-cache refill controller.
package icache_refill_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;
  localparam int FETCH_BYTES     = INST_BUS_W / 8;
  localparam int CNT_W           = $clog2(FETCH_BYTES + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       state_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/icache_refill_if.sv
// Fetch-side bundle: IF request/response, cache probe/write and byte-wide memory port.
//
// Handshakes: IF holds if_req/if_pc stable until a one-cycle inst_valid pulse answers it;
// a byte read transfers on any cycle with mem_rd & mem_grant, and its data is on mem_din
// exactly one cycle later. mem_rd/mem_addr stay put while mem_grant is low.
interface icache_refill_if #(
  parameter int ADDR_W = icache_refill_pkg::INST_ADDR_BUS_W,
  parameter int INST_W = icache_refill_pkg::INST_BUS_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_pc;
  logic              flush;
  logic              inst_valid;
  logic [INST_W-1:0] inst;

  logic [ADDR_W-1:0] cache_addr;
  logic [INST_W-1:0] cache_wdata;
  logic              cache_we;
  logic [INST_W-1:0] cache_rdata;
  logic              cache_hit;

  logic              mem_grant;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;

  modport master (
    input  if_req, if_pc, flush, cache_rdata, cache_hit, mem_grant, mem_din,
    output inst_valid, inst, cache_addr, cache_wdata, cache_we, mem_rd, mem_addr
  );

  modport slave (
    output if_req, if_pc, flush, cache_rdata, cache_hit, mem_grant, mem_din,
    input  inst_valid, inst, cache_addr, cache_wdata, cache_we, mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_refill_byte_assembler.sv
// Collects returned memory bytes into a little-endian word; word already includes
// the byte being captured this cycle so the fill can be written without a bubble.
module icache_refill_byte_assembler
  import icache_refill_pkg::*;
#(
  parameter int INST_W = INST_BUS_W,
  parameter int NBYTES = FETCH_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              capture,
  input  logic [7:0]        din,
  output logic [INST_W-1:0] word,
  output logic              last
);

  logic [INST_W-1:0] word_q;
  cnt_t              recv_cnt;

  always_comb begin
    word = word_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (capture && (recv_cnt == cnt_t'(k))) word[8*k +: 8] = din;
    end
  end

  assign last = capture && (recv_cnt == cnt_t'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      recv_cnt <= '0;
    end else if (en) begin
      if (clear) begin
        word_q   <= '0;
        recv_cnt <= '0;
      end else if (capture) begin
        word_q   <= word;
        recv_cnt <= recv_cnt + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/icache_refill.sv
// Instruction-fetch cache controller: serves hits in one cycle, refills misses
// byte-by-byte from memory, writes the assembled word to the cache and returns it to IF.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W,
  parameter int NBYTES = FETCH_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  icache_refill_if.master bus,
  output logic [1:0]      dbg_state
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  cnt_t              issue_cnt;
  logic              pending_q;
  logic              inst_valid_q, cache_we_q;
  logic [INST_W-1:0] inst_q, cache_wdata_q;
  logic [INST_W-1:0] word;
  logic              accept, hit_take, miss_start;
  logic              issue, grant_take, capture, last_byte, fill_done, asm_clear;

  // A request is only looked at in IDLE and never in the cycle its answer is on inst_valid.
  always_comb begin
    accept     = (state_q == S_IDLE) && bus.if_req && !bus.flush && !inst_valid_q;
    hit_take   = accept && bus.cache_hit;
    miss_start = accept && !bus.cache_hit;
    issue      = (state_q == S_FETCH) && (issue_cnt < cnt_t'(NBYTES));
    grant_take = issue && bus.mem_grant;
    capture    = (state_q == S_FETCH) && pending_q;
    fill_done  = last_byte && !bus.flush;
    asm_clear  = bus.flush || miss_start;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (miss_start) state_d = S_FETCH;
        S_FETCH: if (last_byte) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  icache_refill_byte_assembler #(
    .INST_W (INST_W),
    .NBYTES (NBYTES)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy),
    .clear   (asm_clear),
    .capture (capture),
    .din     (bus.mem_din),
    .word    (word),
    .last    (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      issue_cnt     <= '0;
      pending_q     <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= '0;
      cache_we_q    <= 1'b0;
      cache_wdata_q <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      inst_valid_q <= 1'b0;
      cache_we_q   <= 1'b0;
      if (hit_take) begin
        inst_valid_q <= 1'b1;
        inst_q       <= bus.cache_rdata;
      end
      // Outputs are registered on entry to DONE so they are visible during DONE.
      if (fill_done) begin
        inst_valid_q  <= 1'b1;
        inst_q        <= word;
        cache_we_q    <= 1'b1;
        cache_wdata_q <= word;
      end
      if (miss_start) pc_q <= bus.if_pc;
      if (bus.flush || miss_start) begin
        issue_cnt <= '0;
        pending_q <= 1'b0;
      end else begin
        pending_q <= grant_take;
        if (grant_take) issue_cnt <= issue_cnt + cnt_t'(1);
      end
    end
  end

  assign bus.inst_valid  = inst_valid_q;
  assign bus.inst        = inst_q;
  assign bus.cache_we    = cache_we_q;
  assign bus.cache_wdata = cache_wdata_q;
  assign bus.cache_addr  = (state_q == S_IDLE) ? bus.if_pc : pc_q;
  assign bus.mem_rd      = issue;
  assign bus.mem_addr    = pc_q + ADDR_W'(issue_cnt);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: cache and byte-memory models around the DUT, IF-side driver,
// and a scoreboard matching every inst_valid pulse against the expected word.
module tb_icache_refill;
  import icache_refill_pkg::*;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic [1:0] dbg_state;

  icache_refill_if #(.ADDR_W(32), .INST_W(32)) bus ();

  icache_refill dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check / counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- byte memory model ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  logic        rdy_s = 1'b0;
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = '0;
  int          rd_cnt = 0;
  logic [31:0] gnt_addr_q[$];

  always @(posedge clk) begin
    rdy_s <= rdy;
    if (rdy && !rst && bus.mem_rd && bus.mem_grant) begin
      resp_pend <= 1'b1;
      resp_addr <= bus.mem_addr;
      gnt_addr_q.push_back(bus.mem_addr);
    end else begin
      resp_pend <= 1'b0;
    end
    if (rdy && !rst && bus.mem_rd) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) bus.mem_din = resp_pend ? mem_byte(resp_addr) : 8'hEE;

  // ---------------- direct-mapped cache model ----------------
  logic        c_valid [4096];
  logic [31:0] c_tag   [4096];
  logic [31:0] c_data  [4096];
  logic        inv_all, pre_we;
  logic [31:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (inv_all) begin
      for (int i = 0; i < 4096; i++) c_valid[i] <= 1'b0;
    end else if (bus.cache_we) begin
      c_valid[bus.cache_addr[13:2]] <= 1'b1;
      c_tag[bus.cache_addr[13:2]]   <= bus.cache_addr;
      c_data[bus.cache_addr[13:2]]  <= bus.cache_wdata;
    end else if (pre_we) begin
      c_valid[pre_addr[13:2]] <= 1'b1;
      c_tag[pre_addr[13:2]]   <= pre_addr;
      c_data[pre_addr[13:2]]  <= pre_data;
    end
  end

  assign bus.cache_hit   = c_valid[bus.cache_addr[13:2]] && (c_tag[bus.cache_addr[13:2]] == bus.cache_addr);
  assign bus.cache_rdata = c_data[bus.cache_addr[13:2]];

  function automatic logic cache_has(input logic [31:0] a);
    return c_valid[a[13:2]] && (c_tag[a[13:2]] == a);
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        fill_q[$];
  logic [31:0] addr_q[$];
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (rdy_s === 1'b1) begin
      if (bus.inst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          logic [31:0] w, a;
          logic        f;
          w = exp_q.pop_front();
          f = fill_q.pop_front();
          a = addr_q.pop_front();
          check("inst", bus.inst, w);
          check("cache_we", {31'd0, bus.cache_we}, {31'd0, f});
          if (f) begin
            check("cache_wdata", bus.cache_wdata, w);
            check("cache_addr", bus.cache_addr, a);
          end
        end
      end
      if (bus.cache_we === 1'b1 && bus.inst_valid !== 1'b1) check("stray_we", 32'd1, 32'd0);
      if (bus.inst_valid === 1'b1 && prev_v) check("valid_pulse", 32'd1, 32'd0);
      prev_v = (bus.inst_valid === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cache_init();
    inv_all = 1'b1;
    @(negedge clk);
    inv_all  = 1'b0;
    pre_we   = 1'b1;
    pre_addr = 32'h0000_1000;
    pre_data = 32'h00A0_0093;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input bit hit, input int exp_lat,
                       input logic [15:0] stall, input int pre_frz, input int post_frz);
    int          cyc;
    int          rd0;
    bit          seen;
    logic [31:0] w;
    w = ref_word(pc);
    exp_q.push_back(w);
    fill_q.push_back(!hit);
    addr_q.push_back(pc);
    gnt_addr_q.delete();
    rd0 = rd_cnt;
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    if (pre_frz > 0) begin
      rdy = 1'b0;
      repeat (pre_frz) begin
        @(negedge clk);
        check({tag, "_frz_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        check({tag, "_frz_state"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
      end
      rdy = 1'b1;
    end
    cyc  = 0;
    seen = 1'b0;
    bus.mem_grant = !stall[0];
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_grant = (cyc < 16) ? !stall[cyc] : 1'b1;
      seen = (bus.inst_valid === 1'b1);
    end
    bus.if_req    = 1'b0;
    bus.mem_grant = 1'b1;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    else       check({tag, "_lat"}, cyc, exp_lat);
    if (seen && post_frz > 0) begin
      rdy = 1'b0;
      repeat (post_frz) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'd0, bus.inst_valid}, 32'd1);
        check({tag, "_hold_state"}, {30'd0, dbg_state}, hit ? {30'd0, S_IDLE} : {30'd0, S_DONE});
        check({tag, "_hold_inst"}, bus.inst, w);
      end
      rdy = 1'b1;
    end
    @(negedge clk);
    check({tag, "_after_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    if (hit) begin
      check({tag, "_no_mem_rd"}, rd_cnt - rd0, 32'd0);
    end else begin
      check({tag, "_n_bytes"}, gnt_addr_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (i < gnt_addr_q.size()) check({tag, "_byte_addr"}, gnt_addr_q[i], pc + 32'(i));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   pulses;
    int   pcyc [2];
    logic [31:0] rnd_base [5];

    rst = 1'b1;
    rdy = 1'b1;
    bus.if_req = 1'b0;
    bus.if_pc = '0;
    bus.flush = 1'b0;
    bus.mem_grant = 1'b1;
    inv_all = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;

    mem[32'h4] = 8'h13; mem[32'h5] = 8'h05; mem[32'h6] = 8'h00; mem[32'h7] = 8'h00;
    mem[32'h1000] = 8'h93; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'hA0; mem[32'h1003] = 8'h00;
    rnd_base = '{32'h2000, 32'h3000, 32'h0040, 32'h0080, 32'h5040};
    foreach (rnd_base[j])
      for (int i = 0; i < 4; i++) mem[rnd_base[j] + 32'(i)] = 8'($urandom_range(0, 255));

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_we", {31'd0, bus.cache_we}, 32'd0);
    check("rst_wdata", bus.cache_wdata, 32'd0);
    check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst = 1'b0;
    cache_init();

    fetch("hit", 32'h1000, 1'b1, 1, 16'h0, 0, 0);
    fetch("cold_miss", 32'h4, 1'b0, 6, 16'h0, 0, 0);
    fetch("rehit", 32'h4, 1'b1, 1, 16'h0, 0, 0);
    cache_init();
    fetch("stall_miss", 32'h4, 1'b0, 8, 16'h000C, 0, 0);

    // Request held through the response: the pulse cycle is ignored, so the repeat lands 2 later.
    repeat (2) begin
      exp_q.push_back(ref_word(32'h1000));
      fill_q.push_back(1'b0);
      addr_q.push_back(32'h1000);
    end
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h1000;
    pulses = 0;
    pcyc = '{0, 0};
    for (int c = 1; c <= 8 && pulses < 2; c++) begin
      @(negedge clk);
      if (bus.inst_valid === 1'b1) begin
        pcyc[pulses] = c;
        pulses++;
      end
    end
    bus.if_req = 1'b0;
    check("turn_pulses", pulses, 2);
    check("turn_first", pcyc[0], 1);
    check("turn_second", pcyc[1], 3);
    @(negedge clk);

    // Flush in cycle 3 of a miss.
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h3000;
    repeat (3) @(negedge clk);
    bus.flush  = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("flush_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    repeat (8) @(negedge clk);
    check("flush_no_fill", {31'd0, cache_has(32'h3000)}, 32'd0);
    fetch("after_flush", 32'h0040, 1'b0, 6, 16'h0, 0, 0);

    fetch("b2b_hit", 32'h1000, 1'b1, 1, 16'h0, 0, 0);
    fetch("b2b_miss", 32'h2000, 1'b0, 6, 16'h0, 0, 0);

    fetch("rdy_idle", 32'h1000, 1'b1, 1, 16'h0, 3, 0);
    fetch("rdy_done", 32'h0080, 1'b0, 6, 16'h0, 0, 3);

    // Reset while refilling.
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h5040;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    check("mrst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("mrst_inst", bus.inst, 32'd0);
    check("mrst_we", {31'd0, bus.cache_we}, 32'd0);
    check("mrst_wdata", bus.cache_wdata, 32'd0);
    check("mrst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("mrst_mem_addr", bus.mem_addr, 32'd0);
    check("mrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_no_fill", {31'd0, cache_has(32'h5040)}, 32'd0);
    fetch("after_rst", 32'h5040, 1'b0, 6, 16'h0, 0, 0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
